level_receiver: RTL and testbench

- Clocked receiver on the high-voltage side of level_shifter. Samples the real-valued VOUT of the shifter and converts it into a clean, debounced digital bit.
- Applies hysteresis thresholds scaled to VCC_HIGH, a glitch filter and supply-valid supervision.
- Feeds digital logic in the VCC_HIGH domain; gives the bench an end-to-end path (real in -> shifted real -> logic out).

---
 rtl/level_pkg.sv | 20 ++
 rtl/level_hyst_cmp.sv | 31 +++
 rtl/level_receiver.sv | 125 ++++++++++++
 tb/tb_level_receiver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
// Shared types and default analog constants for the level receiver path.
// The threshold defaults are shared with the level_shifter THRESHOLD handling.
package level_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    localparam real VTH_HI_FRAC_DEF = 0.6;
    localparam real VTH_LO_FRAC_DEF = 0.4;
    localparam real VCC_MIN_DEF     = 1.0;

    // A non-positive rail is never valid, whatever the configured minimum is.
    function automatic logic supply_good(input real vcc, input real vmin);
        return (vcc > 0.0) && (vcc >= vmin);
    endfunction

endpackage

// File: rtl/level_hyst_cmp.sv
// Hysteresis comparator: registers a candidate bit from VIN against rail-scaled
// rising and falling thresholds, holding the previous value inside the band.
module level_hyst_cmp #(
    parameter real VTH_HI_FRAC = 0.6,
    parameter real VTH_LO_FRAC = 0.4
) (
    input  logic clk,
    input  logic rst_n,
    input  real  vin,
    input  real  vcc_high,
    output logic cand
);

    logic above_hi;
    logic below_lo;

    // Thresholds are products, never quotients, so a zero rail is harmless.
    assign above_hi = (vin >= VTH_HI_FRAC * vcc_high);
    assign below_lo = (vin <= VTH_LO_FRAC * vcc_high);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand <= 1'b0;
        end else if (above_hi) begin
            cand <= 1'b1;
        end else if (below_lo) begin
            cand <= 1'b0;
        end
    end

endmodule

// File: rtl/level_receiver.sv
// High-side receiver: hysteresis candidate, debounced DOUT with edge pulses,
// supply supervision and a saturating count of rejected transitions.
module level_receiver
    import level_pkg::*;
#(
    parameter real VTH_HI_FRAC = VTH_HI_FRAC_DEF,
    parameter real VTH_LO_FRAC = VTH_LO_FRAC_DEF,
    parameter real VCC_MIN     = VCC_MIN_DEF,
    parameter int  DEBOUNCE    = 4,
    parameter int  CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  real              VIN,
    input  real              VCC_HIGH,
    input  logic             EN,
    output logic             DOUT,
    output logic             DOUT_VALID,
    output logic             EDGE_RISE,
    output logic             EDGE_FALL,
    output logic             SUPPLY_OK,
    output logic [CNT_W-1:0] GLITCH_CNT,
    output state_t           state_dbg
);

    localparam int DW = $clog2(DEBOUNCE + 1);

    state_t          state;
    logic            cand;
    logic            acq_val;
    logic            supply_now;
    logic [DW-1:0]   db_cnt;
    int              acq_next;
    int              trk_next;

    level_hyst_cmp #(
        .VTH_HI_FRAC (VTH_HI_FRAC),
        .VTH_LO_FRAC (VTH_LO_FRAC)
    ) u_cmp (
        .clk      (CLK),
        .rst_n    (RST_N),
        .vin      (VIN),
        .vcc_high (VCC_HIGH),
        .cand     (cand)
    );

    assign supply_now = supply_good(VCC_HIGH, VCC_MIN);
    assign state_dbg  = state;

    // During acquisition a candidate change restarts the stable run at 1.
    always_comb begin
        acq_next = 1;
        trk_next = int'(db_cnt) + 1;
        if (db_cnt != '0 && cand == acq_val) begin
            acq_next = int'(db_cnt) + 1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= OFF;
            acq_val    <= 1'b0;
            db_cnt     <= '0;
            DOUT       <= 1'b0;
            DOUT_VALID <= 1'b0;
            EDGE_RISE  <= 1'b0;
            EDGE_FALL  <= 1'b0;
            SUPPLY_OK  <= 1'b0;
            GLITCH_CNT <= '0;
        end else begin
            SUPPLY_OK <= supply_now;
            EDGE_RISE <= 1'b0;
            EDGE_FALL <= 1'b0;
            case (state)
                OFF: begin
                    DOUT       <= 1'b0;
                    DOUT_VALID <= 1'b0;
                    db_cnt     <= '0;
                    if (EN && supply_now) begin
                        state <= ACQUIRE;
                    end
                end
                ACQUIRE, TRACK: begin
                    if (!EN || !supply_now) begin
                        // Shutdown is silent: no EDGE_FALL even when DOUT was 1.
                        state      <= OFF;
                        DOUT       <= 1'b0;
                        DOUT_VALID <= 1'b0;
                        db_cnt     <= '0;
                    end else if (state == ACQUIRE) begin
                        if (acq_next >= DEBOUNCE) begin
                            DOUT       <= cand;
                            DOUT_VALID <= 1'b1;
                            db_cnt     <= '0;
                            state      <= TRACK;
                        end else begin
                            db_cnt  <= DW'(acq_next);
                            acq_val <= cand;
                        end
                    end else begin
                        if (cand != DOUT) begin
                            if (trk_next >= DEBOUNCE) begin
                                DOUT      <= cand;
                                EDGE_RISE <= cand;
                                EDGE_FALL <= !cand;
                                db_cnt    <= '0;
                            end else begin
                                db_cnt <= DW'(trk_next);
                            end
                        end else if (db_cnt != '0) begin
                            db_cnt <= '0;
                            if (GLITCH_CNT != '1) begin
                                GLITCH_CNT <= GLITCH_CNT + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_level_receiver.sv
// Bench for level_receiver: directed level checks plus an edge-pulse scoreboard
// holding the expected kind and cycle of every EDGE_RISE/EDGE_FALL pulse.
`timescale 1ns/1ps
module tb_level_receiver;
    import level_pkg::*;

    localparam int DEB   = 4;
    localparam int CNT_W = 8;

    logic             CLK;
    logic             RST_N;
    real              VIN;
    real              VCC_HIGH;
    logic             EN;
    logic             DOUT;
    logic             DOUT_VALID;
    logic             EDGE_RISE;
    logic             EDGE_FALL;
    logic             SUPPLY_OK;
    logic [CNT_W-1:0] GLITCH_CNT;
    state_t           state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Entry: bit 32 = 1 for a rise, 0 for a fall; bits 31:0 = cycle it must show.
    logic [32:0] exp_q[$];

    level_receiver #(
        .DEBOUNCE (DEB),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .VIN        (VIN),
        .VCC_HIGH   (VCC_HIGH),
        .EN         (EN),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .EDGE_RISE  (EDGE_RISE),
        .EDGE_FALL  (EDGE_FALL),
        .SUPPLY_OK  (SUPPLY_OK),
        .GLITCH_CNT (GLITCH_CNT),
        .state_dbg  (state_dbg)
    );

    // Clock and cycle counter
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic push_edge(input logic rise);
        exp_q.push_back({rise, 32'(cyc + 1 + DEB)});
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_dout"},   32'(DOUT),       32'd0);
        check_val({tag, "_valid"},  32'(DOUT_VALID), 32'd0);
        check_val({tag, "_rise"},   32'(EDGE_RISE),  32'd0);
        check_val({tag, "_fall"},   32'(EDGE_FALL),  32'd0);
        check_val({tag, "_supply"}, 32'(SUPPLY_OK),  32'd0);
        check_val({tag, "_glitch"}, 32'(GLITCH_CNT), 32'd0);
        check_val({tag, "_state"},  32'(state_dbg),  32'(OFF));
    endtask

    // Scoreboard: every pulse must match the head of the queue; stale heads are misses.
    always @(negedge CLK) begin
        logic [32:0] e;
        if (EDGE_RISE || EDGE_FALL) begin
            if (exp_q.size() == 0) begin
                check_val("edge_unexpected", 32'({EDGE_RISE, EDGE_FALL}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("edge_kind",  32'({EDGE_RISE, EDGE_FALL}), e[32] ? 32'd2 : 32'd1);
                check_val("edge_cycle", 32'(cyc), e[31:0]);
            end
        end else if (exp_q.size() != 0 && int'(exp_q[0][31:0]) < cyc) begin
            e = exp_q.pop_front();
            check_val("edge_missing", 32'(cyc), e[31:0]);
        end
    end

    initial begin
        RST_N    = 1'b0;
        EN       = 1'b1;
        VCC_HIGH = 1.8;
        VIN      = 1.5;

        // Reset state and acquisition from reset
        steps(3);
        check_all_zero("reset");
        RST_N = 1'b1;
        steps(DEB);
        check_val("acq_valid_early", 32'(DOUT_VALID), 32'd0);
        step();
        check_val("acq_valid", 32'(DOUT_VALID), 32'd1);
        check_val("acq_dout",  32'(DOUT),       32'd1);
        check_val("acq_state", 32'(state_dbg),  32'(TRACK));
        check_val("acq_supply", 32'(SUPPLY_OK), 32'd1);

        // Clean falling step: DOUT changes exactly DEB cycles after first sample
        VIN = 0.2;
        push_edge(1'b0);
        steps(DEB);
        check_val("fall_dout_early", 32'(DOUT), 32'd1);
        step();
        check_val("fall_dout", 32'(DOUT), 32'd0);
        steps(3);
        check_val("fall_glitch", 32'(GLITCH_CNT), 32'd0);

        // Hysteresis sweep at 1.8 V rail: rise at 1.08 V, fall at 0.72 V
        for (int i = 0; i <= 120; i++) begin
            VIN = real'(i) / 100.0;
            if (i == 108) push_edge(1'b1);
            steps(10);
            check_val("sweep_up_dout", 32'(DOUT), (i >= 108) ? 32'd1 : 32'd0);
        end
        for (int i = 120; i >= 0; i--) begin
            VIN = real'(i) / 100.0;
            if (i == 72) push_edge(1'b0);
            steps(10);
            check_val("sweep_dn_dout", 32'(DOUT), (i >= 73) ? 32'd1 : 32'd0);
        end
        check_val("sweep_glitch", 32'(GLITCH_CNT), 32'd0);

        // Short pulses are rejected and counted, saturating at all-ones
        for (int g = 1; g <= 300; g++) begin
            VIN = 1.5;
            steps(2);
            VIN = 0.2;
            steps(3);
            if (g == 1 || g == 10 || g == 255) begin
                check_val("glitch_cnt", 32'(GLITCH_CNT), 32'(g));
                check_val("glitch_dout", 32'(DOUT), 32'd0);
            end
        end
        check_val("glitch_sat", 32'(GLITCH_CNT), 32'd255);

        // Supply drop from DOUT=1 clears silently, then reacquires
        VIN = 1.5;
        push_edge(1'b1);
        steps(10);
        check_val("pre_drop_dout", 32'(DOUT), 32'd1);
        VCC_HIGH = 0.8;
        step();
        check_val("drop_supply", 32'(SUPPLY_OK),  32'd0);
        check_val("drop_dout",   32'(DOUT),       32'd0);
        check_val("drop_valid",  32'(DOUT_VALID), 32'd0);
        check_val("drop_fall",   32'(EDGE_FALL),  32'd0);
        check_val("drop_state",  32'(state_dbg),  32'(OFF));
        check_val("drop_glitch", 32'(GLITCH_CNT), 32'd255);
        steps(3);
        VCC_HIGH = 1.8;
        VIN = 2.0;
        steps(DEB);
        check_val("reacq_valid_early", 32'(DOUT_VALID), 32'd0);
        step();
        check_val("reacq_valid", 32'(DOUT_VALID), 32'd1);
        check_val("reacq_dout",  32'(DOUT),       32'd1);

        // Non-positive rail and EN low both force OFF
        VCC_HIGH = -1.0;
        step();
        check_val("neg_rail_valid", 32'(DOUT_VALID), 32'd0);
        check_val("neg_rail_supply", 32'(SUPPLY_OK), 32'd0);
        VCC_HIGH = 1.8;
        steps(DEB + 1);
        check_val("neg_rail_reacq", 32'(DOUT_VALID), 32'd1);
        EN = 1'b0;
        step();
        check_val("en_low_state", 32'(state_dbg), 32'(OFF));
        check_val("en_low_dout",  32'(DOUT),      32'd0);
        EN = 1'b1;
        steps(DEB + 1);
        check_val("en_reacq_dout", 32'(DOUT), 32'd1);

        // Reset in the middle of a debounce run
        VIN = -2.0;
        steps(3);
        check_val("mid_dout_held", 32'(DOUT), 32'd1);
        RST_N = 1'b0;
        step();
        check_all_zero("mid_reset");
        RST_N = 1'b1;
        steps(DEB + 1);
        check_val("post_reset_valid", 32'(DOUT_VALID), 32'd1);
        check_val("post_reset_dout",  32'(DOUT),       32'd0);

        steps(5);
        check_val("edge_q_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
